// File: rtl/lab2_pkg.sv
// ============================================================================
// lab2_pkg : shared state encoding and default constants for accum_frame8
// Rev 1.0
// ============================================================================
`default_nettype none

package lab2_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_COUNT_N = 4;

    localparam logic [7:0] SAT_MAX = 8'h7F;
    localparam logic [7:0] SAT_MIN = 8'h80;

endpackage

`default_nettype wire

// File: rtl/partI_add.sv
// ============================================================================
// partI_add : lab ripple adder with carry-in, carry-out and signed overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module partI_add #(
    parameter int WIDTH = 8
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum      = w_full[WIDTH-1:0];
    assign cout     = w_full[WIDTH];
    // b is the effective operand, so subtract overflow is covered by the same rule
    assign overflow = (~a[WIDTH-1] & ~b[WIDTH-1] &  sum[WIDTH-1]) |
                      ( a[WIDTH-1] &  b[WIDTH-1] & ~sum[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/accum_frame8.sv
// ============================================================================
// accum_frame8 : framed add/sub accumulator with sticky overflow and result
//                handshake. Define ACCUM_SAT_EN for saturating accumulation.
// Rev 1.0
// ============================================================================
`default_nettype none

module accum_frame8
    import lab2_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_N = DEF_COUNT_N,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             acc_cout,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COUNT_N - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic               r_cout;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_ovf;

    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_accept;

    assign w_b = in_sub ? ~in_data : in_data;

    partI_add #(
        .WIDTH    (WIDTH)
    ) u_add (
        .cin      (in_sub),
        .a        (r_acc),
        .b        (w_b),
        .sum      (w_sum),
        .cout     (w_cout),
        .overflow (w_ovf)
    );

`ifdef ACCUM_SAT_EN
    // on overflow both effective operands share a sign; clamp toward it
    assign w_acc_next = !w_ovf         ? w_sum   :
                        r_acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
`else
    assign w_acc_next = w_sum;
`endif

    assign in_ready = reset_n & (r_state == ACCUM) & ~clear;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc    <= w_acc_next;
                        r_cout   <= w_cout;
                        r_sticky <= r_sticky | w_ovf;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (r_cnt == C_LAST) begin
                            r_state     <= DONE;
                            r_out_data  <= w_acc_next;
                            r_out_ovf   <= r_sticky | w_ovf;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // acc_cout deliberately survives the frame hand-off
                    if (out_ready) begin
                        r_state     <= ACCUM;
                        r_acc       <= '0;
                        r_sticky    <= 1'b0;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign acc_cout  = r_cout;
    assign op_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_accum_frame8.sv
// ============================================================================
// tb_accum_frame8 : vector table plus corner sequences for accum_frame8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_accum_frame8;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       acc_cout;
    logic [7:0] op_count;

    accum_frame8 #(
        .WIDTH    (8),
        .COUNT_N  (4),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .acc_cout  (acc_cout),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d   [4];
        logic       sub [4];
        logic       cout2;
        logic [7:0] exp_data;
        logic [7:0] exp_data_sat;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
    } res_t;

    res_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pick(input vec_t v);
`ifdef ACCUM_SAT_EN
        return v.exp_data_sat;
`else
        return v.exp_data;
`endif
    endfunction

    // Presents one operand and returns #1 after the edge that accepted it.
    task automatic drive_op(input logic [7:0] d, input logic s);
        logic took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        for (int k = 0; k < 20 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !clear) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("sb_out_data", {24'd0, out_data}, {24'd0, e.data});
                chk("sb_out_ovf",  {31'd0, out_ovf},  {31'd0, e.ovf});
            end
        end
    end

    vec_t vt[6];

    initial begin
        res_t r;
        vt[0] = '{d:'{8'd10, 8'd20, 8'd30, 8'd40},  sub:'{0,0,0,0}, cout2:1'b0,
                  exp_data:8'h64, exp_data_sat:8'h64, exp_ovf:1'b0};
        vt[1] = '{d:'{8'd100, 8'd100, 8'd0, 8'd0}, sub:'{0,0,0,0}, cout2:1'b0,
                  exp_data:8'hC8, exp_data_sat:8'h7F, exp_ovf:1'b1};
        vt[2] = '{d:'{8'd5, 8'd7, 8'd0, 8'd0},     sub:'{0,1,0,0}, cout2:1'b0,
                  exp_data:8'hFE, exp_data_sat:8'hFE, exp_ovf:1'b0};
        vt[3] = '{d:'{8'd1, 8'd1, 8'd1, 8'd1},     sub:'{1,1,1,1}, cout2:1'b1,
                  exp_data:8'hFC, exp_data_sat:8'hFC, exp_ovf:1'b0};
        vt[4] = '{d:'{8'h80, 8'd1, 8'd0, 8'd0},    sub:'{0,1,0,0}, cout2:1'b1,
                  exp_data:8'h7F, exp_data_sat:8'h80, exp_ovf:1'b1};
        vt[5] = '{d:'{8'd127, 8'd1, 8'd1, 8'd0},   sub:'{0,0,1,0}, cout2:1'b0,
                  exp_data:8'h7F, exp_data_sat:8'h7E, exp_ovf:1'b1};

        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
        chk("rst_op_count",  {24'd0, op_count},  32'd0);
        chk("rst_acc_cout",  {31'd0, acc_cout},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        #29 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // table-driven frames, back-to-back operands, downstream always ready
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3) begin
                    r.data = pick(vt[i]);
                    r.ovf  = vt[i].exp_ovf;
                    sb_q.push_back(r);
                end
                drive_op(vt[i].d[j], vt[i].sub[j]);
                if (j == 1) chk("cout_after_2nd", {31'd0, acc_cout}, {31'd0, vt[i].cout2});
                if (j < 3)  chk("op_count_accum", {24'd0, op_count}, j + 1);
            end
            in_valid = 1'b0;
            @(negedge clk);
            chk("done_latency_valid", {31'd0, out_valid}, 32'd1);
            chk("done_op_count",      {24'd0, op_count},  32'd4);
            @(posedge clk); #1;
            @(negedge clk);
            chk("after_done_valid", {31'd0, out_valid}, 32'd0);
            chk("after_done_count", {24'd0, op_count},  32'd0);
            @(posedge clk); #1;
        end

        // backpressure in DONE with in_valid held high
        out_ready = 1'b0;
        drive_op(8'd10, 1'b0);
        drive_op(8'd20, 1'b0);
        drive_op(8'd30, 1'b0);
        r.data = 8'h64; r.ovf = 1'b0;
        sb_q.push_back(r);
        drive_op(8'd40, 1'b0);
        in_data = 8'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data",  {24'd0, out_data},  32'h64);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_op_count",  {24'd0, op_count},  32'd4);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready},  32'd1);
        chk("bp_release_valid",    {31'd0, out_valid}, 32'd0);
        chk("bp_release_count",    {24'd0, op_count},  32'd0);
        @(posedge clk); #1;
        // accumulator must restart from zero: 1+1+1+1
        drive_op(8'd1, 1'b0);
        drive_op(8'd1, 1'b0);
        drive_op(8'd1, 1'b0);
        r.data = 8'h04; r.ovf = 1'b0;
        sb_q.push_back(r);
        drive_op(8'd1, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // clear after two accepts, with an operand on offer
        drive_op(8'hC8, 1'b0);
        drive_op(8'h64, 1'b0);
        chk("pre_clear_cout", {31'd0, acc_cout}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'd70;
        clear    = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_op_count", {24'd0, op_count}, 32'd0);
        chk("clear_acc_cout", {31'd0, acc_cout}, 32'd0);
        drive_op(8'd1, 1'b0);
        drive_op(8'd2, 1'b0);
        drive_op(8'd3, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clear_no_early_valid", {31'd0, out_valid}, 32'd0);
        chk("clear_count_3",        {24'd0, op_count},  32'd3);
        @(posedge clk); #1;
        r.data = 8'h0A; r.ovf = 1'b0;
        sb_q.push_back(r);
        drive_op(8'd4, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clear_frame_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // asynchronous reset while holding a result in DONE
        out_ready = 1'b0;
        drive_op(8'd100, 1'b0);
        drive_op(8'd100, 1'b0);
        drive_op(8'd0, 1'b0);
        drive_op(8'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data",  {24'd0, out_data},  32'd0);
        chk("arst_out_ovf",   {31'd0, out_ovf},   32'd0);
        chk("arst_op_count",  {24'd0, op_count},  32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk); #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("arst_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
